// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - raster timing constants, register bit indices and status bit positions for the VDP timing stage
package vdp_pkg;

  // 640x480@60 horizontal timing, in pixel clocks
  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP   = 10'd48;

  // 640x480@60 vertical timing, in lines
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP   = 10'd33;

  // derived raster totals (800 clocks per line, 525 lines per frame)
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // sync pulse windows, inclusive
  localparam logic [9:0] H_SYNC_FIRST = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_LAST  = H_VIS + H_FP + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_FIRST = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_LAST  = V_VIS + V_FP + V_SYNC - 10'd1;

  // the 192 SMS lines are line-doubled onto VGA rows Y_OFS..ACTIVE_LAST
  localparam logic [9:0] SMS_LINES   = 10'd192;
  localparam logic [9:0] Y_OFS       = 10'd48;
  localparam logic [9:0] ACTIVE_LAST = Y_OFS + (SMS_LINES << 1) - 10'd1;

  // the line tick fires on the last visible pixel of each VGA row
  localparam logic [9:0] LINE_TICK_COL = H_VIS - 10'd1;

  // register file indices and enable bits
  localparam int REG0_LINE_IE    = 4;
  localparam int REG1_FRAME_IE   = 5;
  localparam int LINE_RELOAD_REG = 10;

  // status register bit positions
  localparam int STAT_FRAME_BIT     = 7;
  localparam int STAT_OVERFLOW_BIT  = 6;
  localparam int STAT_COLLISION_BIT = 5;

  // line counter value out of reset
  localparam logic [7:0] LINE_CNT_RESET = 8'hFF;

  // sticky status flags readable through the status port
  typedef struct packed {
    logic frame;
    logic overflow;
    logic collision;
  } status_flags_t;

  // true while the VGA row lies inside the doubled SMS active area
  function automatic logic in_active_rows(input logic [9:0] v);
    return (v >= Y_OFS) && (v <= ACTIVE_LAST);
  endfunction

endpackage

// File: rtl/vdp_line_irq_counter.sv
// rtl/vdp_line_irq_counter.sv - VDP line counter with reload and sticky line interrupt flag
module vdp_line_irq_counter
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_L,
  input  logic       line_tick,
  input  logic       active,
  input  logic       line_end,
  input  logic [7:0] reload,
  input  logic       clear,
  output logic [7:0] line_cnt,
  output logic       line_flag
);

  logic cnt_zero;
  logic fire;

  assign cnt_zero = (line_cnt == 8'd0);
  assign fire     = line_end & cnt_zero;

  // reload through blanking, count down on SMS line ends; a set in the same cycle as a read-clear wins
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      line_cnt  <= LINE_CNT_RESET;
      line_flag <= 1'b0;
    end else begin
      if (line_tick && !active) begin
        line_cnt <= reload;
      end else if (line_end) begin
        line_cnt <= cnt_zero ? reload : (line_cnt - 8'd1);
      end
      line_flag <= fire | (line_flag & ~clear);
    end
  end

endmodule

// File: rtl/vdp_vga_timing.sv
// rtl/vdp_vga_timing.sv - 640x480 raster timing, SMS line/frame interrupts and status register for the VDP
module vdp_vga_timing
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_L,
  input  logic [7:0] regFile [0:10],
  input  logic       sprCollision,
  input  logic       sprOverflow,
  input  logic       statusRead,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       hsync_L,
  output logic       vsync_L,
  output logic [7:0] statusData,
  output logic       IRQ_L
);

  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          line_tick;
  logic          line_end;
  logic          frame_set;
  logic          line_flag;
  logic [7:0]    line_cnt;
  status_flags_t flags;
  logic          unused_regs;

  // only a handful of register bits matter to this stage
  assign unused_regs = ^{regFile[0][7:5], regFile[0][3:0], regFile[1][7:6], regFile[1][4:0],
                         regFile[2], regFile[3], regFile[4], regFile[5], regFile[6],
                         regFile[7], regFile[8], regFile[9], line_cnt};

  assign h_last = (hcount == H_TOTAL - 10'd1);
  assign v_last = (vcount == V_TOTAL - 10'd1);

  // next raster position; rows advance on the horizontal wrap
  always_comb begin
    h_next = hcount + 10'd1;
    v_next = vcount;
    if (h_last) begin
      h_next = 10'd0;
      v_next = v_last ? 10'd0 : (vcount + 10'd1);
    end
  end

  // free-running raster counters; syncs decoded from the next position so they stay aligned with col/row
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      hcount  <= 10'd0;
      vcount  <= 10'd0;
      hsync_L <= 1'b1;
      vsync_L <= 1'b1;
    end else begin
      hcount  <= h_next;
      vcount  <= v_next;
      hsync_L <= ~((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST));
      vsync_L <= ~((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST));
    end
  end

  // rows 512..524 alias onto 0..12, which is harmless because they are all blank
  assign col = hcount;
  assign row = vcount[8:0];

  // an SMS line ends on the odd (second) VGA row of each doubled pair
  assign active    = in_active_rows(vcount);
  assign line_tick = (hcount == LINE_TICK_COL);
  assign line_end  = line_tick & active & vcount[0];
  assign frame_set = line_end & (vcount == ACTIVE_LAST);

  vdp_line_irq_counter u_line (
    .clk       (clk),
    .rst_L     (rst_L),
    .line_tick (line_tick),
    .active    (active),
    .line_end  (line_end),
    .reload    (regFile[LINE_RELOAD_REG]),
    .clear     (statusRead),
    .line_cnt  (line_cnt),
    .line_flag (line_flag)
  );

  // sticky status flags cleared by a status read; a coincident set keeps the flag for the next read
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      flags <= '0;
      IRQ_L <= 1'b1;
    end else begin
      flags.frame     <= frame_set | (flags.frame & ~statusRead);
      flags.overflow  <= (sprOverflow & active) | (flags.overflow & ~statusRead);
      flags.collision <= (sprCollision & active) | (flags.collision & ~statusRead);
      IRQ_L           <= ~((flags.frame & regFile[1][REG1_FRAME_IE]) |
                           (line_flag & regFile[0][REG0_LINE_IE]));
    end
  end

  // status port is read combinationally so the value is valid in the strobe cycle
  always_comb begin
    statusData                     = 8'h00;
    statusData[STAT_FRAME_BIT]     = flags.frame;
    statusData[STAT_OVERFLOW_BIT]  = flags.overflow;
    statusData[STAT_COLLISION_BIT] = flags.collision;
  end

endmodule

// File: tb/tb_vdp_vga_timing.sv
// tb/tb_vdp_vga_timing.sv - self-checking bench for vdp_vga_timing
module tb_vdp_vga_timing;

  logic       clk = 1'b0;
  logic       rst_L;
  logic [7:0] regs [0:10];
  logic       spr_c, spr_o, sread;
  logic [9:0] col;
  logic [8:0] row;
  logic       hsync_L, vsync_L, irq_L;
  logic [7:0] status_data;

  always #20 clk = ~clk;

  vdp_vga_timing dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .regFile      (regs),
    .sprCollision (spr_c),
    .sprOverflow  (spr_o),
    .statusRead   (sread),
    .col          (col),
    .row          (row),
    .hsync_L      (hsync_L),
    .vsync_L      (vsync_L),
    .statusData   (status_data),
    .IRQ_L        (irq_L)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model: raster position is just elapsed cycles since reset
  int         m_t = 0;
  logic       m_frame = 0, m_ovf = 0, m_col = 0, m_line = 0, m_irq = 1;
  logic [7:0] m_cnt = 8'hFF;

  always @(posedge clk) begin : model
    int hc, vc;
    bit act, lend, fire;
    if (!rst_L) begin
      m_t = 0; m_frame = 0; m_ovf = 0; m_col = 0; m_line = 0; m_irq = 1; m_cnt = 8'hFF;
    end else begin
      hc   = m_t % 800;
      vc   = (m_t / 800) % 525;
      act  = (vc >= 48) && (vc <= 431);
      lend = (hc == 639) && act && (vc % 2 == 1);
      fire = lend && (m_cnt == 0);
      m_irq = !((m_frame && regs[1][5]) || (m_line && regs[0][4]));
      if (hc == 639 && !act) m_cnt = regs[10];
      else if (lend) m_cnt = (m_cnt == 0) ? regs[10] : m_cnt - 8'd1;
      m_line  = fire ? 1'b1 : (sread ? 1'b0 : m_line);
      m_frame = (lend && vc == 431) ? 1'b1 : (sread ? 1'b0 : m_frame);
      m_col   = (spr_c && act) ? 1'b1 : (sread ? 1'b0 : m_col);
      m_ovf   = (spr_o && act) ? 1'b1 : (sread ? 1'b0 : m_ovf);
      m_t = (m_t + 1) % 420000;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (row %0d col %0d)", name, act, exp, row, col);
  endtask

  task automatic check_model(string tag);
    int hc = m_t % 800;
    int vc = (m_t / 800) % 525;
    logic [29:0] e;
    e = {10'(hc), 9'(vc % 512), !(hc >= 656 && hc <= 751), !(vc == 490 || vc == 491),
         m_frame, m_ovf, m_col, 5'b0, m_irq};
    chk(tag, {2'b0, col, row, hsync_L, vsync_L, status_data, irq_L}, {2'b0, e});
  endtask

  task automatic step(string tag);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic run_to(int r, int c);
    int target = r * 800 + c;
    int guard = 0;
    while (m_t != target && guard < 60000) begin
      step("model");
      guard++;
    end
    if (m_t != target) begin
      n_chk++;
      $display("FAIL run_to budget: at t=%0d, wanted row %0d col %0d", m_t, r, c);
    end
  endtask

  logic [9:0] jh, jv;

  // move the raster to (r,c) without spending a frame of cycles
  task automatic jump(int r, int c);
    jh = 10'(c - 1);
    jv = 10'(r);
    force dut.hcount = jh;
    force dut.vcount = jv;
    m_t = r * 800 + c - 1;
    @(posedge clk);
    #1;
    jh = 10'(c);
    force dut.hcount = jh;
    release dut.hcount;
    release dut.vcount;
    @(negedge clk);
    check_model("jump");
  endtask

  task automatic do_reset();
    rst_L = 1'b0;
    step("reset");
    rst_L = 1'b1;
  endtask

  typedef enum int {OP_RST, OP_REG, OP_JMP, OP_AT} op_e;
  typedef struct {
    op_e        op;
    int         r;
    int         c;
    bit         rd;
    bit         coll;
    logic [7:0] r0, r1, r10;
    logic       exp_irq;
    logic [7:0] exp_sd;
  } vec_t;

  function automatic vec_t mk(op_e op, int r, int c, bit rd, bit coll,
                              logic [7:0] r0, logic [7:0] r1, logic [7:0] r10,
                              logic ei, logic [7:0] es);
    vec_t v;
    v.op = op; v.r = r; v.c = c; v.rd = rd; v.coll = coll;
    v.r0 = r0; v.r1 = r1; v.r10 = r10; v.exp_irq = ei; v.exp_sd = es;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int lo_cnt, lo_first;
    rst_L = 1'b0; sread = 0; spr_c = 0; spr_o = 0;
    for (int i = 0; i <= 10; i++) regs[i] = 8'h00;
    @(negedge clk);

    // reset state and horizontal/vertical timing
    do_reset();
    chk("reset col", col, 0);
    chk("reset row", row, 0);
    chk("reset hsync", hsync_L, 1);
    chk("reset vsync", vsync_L, 1);
    chk("reset irq", irq_L, 1);
    chk("reset status", status_data, 8'h00);
    chk("reset line_cnt", dut.u_line.line_cnt, 8'hFF);
    run_to(0, 655);  chk("hsync before", hsync_L, 1);
    step("model");   chk("hsync first", hsync_L, 0);
    run_to(0, 751);  chk("hsync last", hsync_L, 0);
    step("model");   chk("hsync after", hsync_L, 1);
    run_to(1, 0);
    lo_cnt = 0; lo_first = -1;
    for (int i = 0; i < 800; i++) begin
      if (!hsync_L) begin
        if (lo_first < 0) lo_first = int'(col);
        lo_cnt++;
      end
      step("model");
    end
    chk("hsync width", lo_cnt, 96);
    chk("hsync start col", lo_first, 656);
    jump(489, 790);
    run_to(489, 799); chk("vsync before", vsync_L, 1);
    step("model");    chk("vsync first", vsync_L, 0);
    chk("vsync row", row, 490);
    run_to(491, 799); chk("vsync last", vsync_L, 0);
    step("model");    chk("vsync after", vsync_L, 1);
    jump(524, 790);
    run_to(524, 799); chk("alias row 524", row, 12);
    step("model");
    chk("wrap col", col, 0);
    chk("wrap row", row, 0);

    // line interrupt (reg10=3 then 0) and frame/collision sequences
    vecs.push_back(mk(OP_RST,   0,   0, 0, 0, 8'h10, 8'h00, 8'h03, 1, 8'h00));
    vecs.push_back(mk(OP_JMP,  47,  10, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   53, 641, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   55, 640, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   55, 641, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,   56,   0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,   56,   1, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,   56,   2, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   61, 641, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   63, 641, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,   64,   0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_REG,   0,   0, 0, 0, 8'h10, 8'h00, 8'h00, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   64,   2, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   69, 641, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   71, 641, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,   72,   0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,   72,   2, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,   73, 641, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_RST,   0,   0, 0, 0, 8'h00, 8'h20, 8'h00, 1, 8'h00));
    vecs.push_back(mk(OP_JMP, 199, 790, 0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,  200, 100, 0, 1, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(OP_AT,  200, 101, 0, 0, 0, 0, 0, 1, 8'h20));
    vecs.push_back(mk(OP_JMP, 431, 600, 0, 0, 0, 0, 0, 1, 8'h20));
    vecs.push_back(mk(OP_AT,  431, 639, 1, 1, 0, 0, 0, 1, 8'h20));
    vecs.push_back(mk(OP_AT,  431, 640, 0, 0, 0, 0, 0, 1, 8'hA0));
    vecs.push_back(mk(OP_AT,  431, 641, 0, 0, 0, 0, 0, 0, 8'hA0));
    vecs.push_back(mk(OP_AT,  431, 700, 1, 0, 0, 0, 0, 0, 8'hA0));
    vecs.push_back(mk(OP_AT,  431, 701, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(OP_AT,  431, 702, 0, 0, 0, 0, 0, 1, 8'h00));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_RST, OP_REG: begin
          regs[0] = vecs[i].r0; regs[1] = vecs[i].r1; regs[10] = vecs[i].r10;
          if (vecs[i].op == OP_RST) do_reset();
        end
        OP_JMP: jump(vecs[i].r, vecs[i].c);
        default: begin
          run_to(vecs[i].r, vecs[i].c);
          chk($sformatf("vec%0d irq", i), irq_L, vecs[i].exp_irq);
          chk($sformatf("vec%0d status", i), status_data, vecs[i].exp_sd);
          sread = vecs[i].rd; spr_c = vecs[i].coll;
          step("model");
          sread = 0; spr_c = 0;
        end
      endcase
    end

    // reset in the middle of a frame with a pending line interrupt
    regs[0] = 8'h10; regs[1] = 8'h00; regs[10] = 8'h00;
    do_reset();
    jump(47, 600);
    run_to(49, 645);
    jump(300, 5);
    chk("pre-reset irq", irq_L, 0);
    do_reset();
    chk("midreset col", col, 0);
    chk("midreset row", row, 0);
    chk("midreset irq", irq_L, 1);
    chk("midreset status", status_data, 8'h00);
    chk("midreset line_cnt", dut.u_line.line_cnt, 8'hFF);

    // randomized traffic against the reference model
    regs[0] = 8'h10; regs[1] = 8'h20; regs[10] = 8'h01;
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if (i % 2500 == 2499) begin
        sread = 0; spr_c = 0; spr_o = 0;
        if ((i / 2500) % 2 == 0) jump(int'($urandom_range(431, 425)), int'($urandom_range(798, 1)));
        else jump(int'($urandom_range(440, 40)), int'($urandom_range(798, 1)));
      end else begin
        sread = ($urandom_range(39) == 0);
        spr_c = ($urandom_range(149) == 0);
        spr_o = ($urandom_range(149) == 0);
        if ($urandom_range(1999) == 0) begin
          regs[0][4]  = 1'($urandom_range(1));
          regs[1][5]  = 1'($urandom_range(1));
          regs[10]    = 8'($urandom_range(3));
        end
        step("random");
      end
    end
    sread = 0; spr_c = 0; spr_o = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
